irrigacao_sequenciador: RTL
===========================

// Module: irrigacao_sequenciador
// PURPOSE
//  Sequences the two irrigation actuators: the sprinkler valve (Vs) and the drip pump (Bs).
//  Both draw from the same tank, so at most one is ever on.
//  Takes raw requests from the irrigation decision logic and the tank status from the level
//  logic. Applies a settle delay, minimum and maximum on-times and a cooldown, and arbitrates
//  round-robin between the two.
//  Drives the actuator outputs, the elapsed-time counter clear, and the state to the LED matrix.
// PARAMETERS
//  SETTLE_S  2    seconds between grant and actuator turn-on
//  MIN_ON_S  5    minimum on-time once started (unless interlock)
//  MAX_ON_S  600  maximum on-time; forces stop
//  COOL_S    10   off-time after any run before the next grant
//  CNT_W     10   second-counter width; must hold MAX_ON_S
// PORTS
//  clk        in   1  system clock
//  reset      in   1  synchronous, active-low reset
//  tick_1hz   in   1  one-clk-wide enable pulse, once per second
//  req_vs     in   1  sprinkler request (level)
//  req_bs     in   1  drip request (level)
//  nivel_ok   in   1  tank usable (not empty)
//  erro       in   1  level-sensor inconsistency
//  clr_fault  in   1  one-clk fault acknowledge
//  vs_out     out  1  sprinkler valve drive
//  bs_out     out  1  drip pump drive
//  timer_clr  out  1  one-clk pulse clearing the elapsed-time display counter
//  estado     out  3  state code: IDLE=0 SETTLE=1 RUN=2 COOL=3 FAULT=4
//  fault      out  1  latched fault flag
//  total_s    out  16 accumulated run seconds (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: sampled low at posedge clk. Forces state=IDLE, cnt=0, sel=VS, last=BS.
//    All outputs 0 (total_s=0). Reset mid-run drops vs_out/bs_out on that edge.
//  - All outputs are registered and reflect the state entered on the same edge.
//  - cnt: increments only on tick_1hz and saturates at MAX_ON_S. Cleared on every state change.
//  - IDLE:
//    - erro=1 -> FAULT.
//    - Else if nivel_ok and any request: grant, go to SETTLE, pulse timer_clr.
//    - Arbitration: a single requester wins. If both request, the one not equal to last wins.
//      last is updated at grant.
//  - SETTLE: outputs 0.
//    - erro -> FAULT.
//    - Selected request drops or nivel_ok=0 -> IDLE (no cooldown).
//    - cnt==SETTLE_S -> RUN.
//  - RUN: the output for sel is 1; the other output is 0. Priority order:
//    1. erro -> FAULT.
//    2. nivel_ok=0 -> COOL (ignores MIN_ON_S).
//    3. cnt==MAX_ON_S -> COOL.
//    4. Selected request low and cnt>=MIN_ON_S -> COOL. A request dropped earlier holds RUN
//       until cnt reaches MIN_ON_S, then goes to COOL if the request is still low.
//  - COOL: outputs 0.
//    - erro -> FAULT.
//    - cnt==COOL_S -> IDLE. Requests are ignored.
//  - FAULT: outputs 0, fault=1.
//    - Exit to IDLE only on clr_fault=1 with erro=0 in the same cycle; fault clears then.
//  - Simultaneous tick and exit condition: the transition wins, and cnt clears rather than
//    increments.
//  - vs_out and bs_out are never 1 together in any cycle.
// CONFIGURATION
//  IRRIG_RUNTIME_LOG_EN defined:
//    - total_s increments on each tick_1hz while in RUN and saturates at 16'hFFFF.
//    - Cleared only by reset.
//  Not defined: total_s is tied to 0 and no counter logic is inferred.
// TESTING (bench params SETTLE_S=1 MIN_ON_S=3 MAX_ON_S=8 COOL_S=2)
//  1. req_vs=1, nivel_ok=1 from IDLE.
//     -> timer_clr pulse; vs_out=1 after 1 tick; held for 8 ticks; COOL 2 ticks; IDLE.
//  2. req_vs dropped after 1 tick of RUN.
//     -> vs_out stays 1 until cnt=3, then COOL.
//  3. req_vs=req_bs=1 continuously.
//     -> alternating grants VS, BS, VS; vs_out&bs_out never both 1.
//  4. nivel_ok->0 at RUN cnt=1.
//     -> next edge: output 0, estado=3; erro=1 in RUN -> estado=4, fault=1.
//  5. In FAULT: clr_fault with erro=1 -> stays FAULT; erro=0 + clr_fault -> IDLE, fault=0.
//  6. reset=0 during RUN -> outputs 0 at that edge. With IRRIG_RUNTIME_LOG_EN:
//     total_s=5 after 5 RUN ticks, then reset -> 0.

Source files
------------

// File: rtl/irrigacao_sequenciador_if.sv
// Bus between the irrigation decision/level logic and the actuator sequencer.
// Handshake: none; every signal is a level or a one-clock pulse sampled on the rising clock edge.
interface irrigacao_sequenciador_if;
    logic        tick_1hz;
    logic        req_vs;
    logic        req_bs;
    logic        nivel_ok;
    logic        erro;
    logic        clr_fault;
    logic        vs_out;
    logic        bs_out;
    logic        timer_clr;
    logic [2:0]  estado;
    logic        fault;
    logic [15:0] total_s;

    modport master (
        output tick_1hz, req_vs, req_bs, nivel_ok, erro, clr_fault,
        input  vs_out, bs_out, timer_clr, estado, fault, total_s
    );

    modport slave (
        input  tick_1hz, req_vs, req_bs, nivel_ok, erro, clr_fault,
        output vs_out, bs_out, timer_clr, estado, fault, total_s
    );
endinterface

// File: rtl/irrigacao_sequenciador.sv
// Sprinkler/drip actuator sequencer: settle, min/max on-time, cooldown, round-robin, fault latch.
// Optional IRRIG_RUNTIME_LOG_EN adds a saturating count of seconds spent in RUN on total_s.
module irrigacao_sequenciador #(
    parameter int SETTLE_S = 2,
    parameter int MIN_ON_S = 5,
    parameter int MAX_ON_S = 600,
    parameter int COOL_S   = 10,
    parameter int CNT_W    = 10
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    irrigacao_sequenciador_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_RUN    = 3'd2,
        S_COOL   = 3'd3,
        S_FAULT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] L_SETTLE = CNT_W'(SETTLE_S);
    localparam logic [CNT_W-1:0] L_MIN    = CNT_W'(MIN_ON_S);
    localparam logic [CNT_W-1:0] L_MAX    = CNT_W'(MAX_ON_S);
    localparam logic [CNT_W-1:0] L_COOL   = CNT_W'(COOL_S);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sel;      // 0 = sprinkler (VS), 1 = drip (BS)
    logic             r_last;
    logic             w_sel_next;
    logic             w_grant;
    logic             w_req_sel;
    logic             w_vs_d;
    logic             w_bs_d;
    logic             w_fault_d;
    logic             r_vs;
    logic             r_bs;
    logic             r_timer_clr;
    logic             r_fault;

    assign w_req_sel = r_sel ? bus.req_bs : bus.req_vs;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_vs        <= 1'b0;
            r_bs        <= 1'b0;
            r_timer_clr <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state <= w_next;
            // A state change clears the counter even when a tick arrives in the same cycle.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (bus.tick_1hz && (r_cnt < L_MAX))
                r_cnt <= r_cnt + 1'b1;
            if (w_grant) begin
                r_sel  <= w_sel_next;
                r_last <= w_sel_next;
            end
            r_vs        <= w_vs_d;
            r_bs        <= w_bs_d;
            r_timer_clr <= w_grant;
            r_fault     <= w_fault_d;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_sel_next = r_sel;
        case (r_state)
            S_IDLE: begin
                if (bus.erro) begin
                    w_next = S_FAULT;
                end else if (bus.nivel_ok && (bus.req_vs || bus.req_bs)) begin
                    w_next     = S_SETTLE;
                    w_grant    = 1'b1;
                    w_sel_next = (bus.req_vs && bus.req_bs) ? ~r_last : bus.req_bs;
                end
            end
            S_SETTLE: begin
                if (bus.erro)                        w_next = S_FAULT;
                else if (!w_req_sel || !bus.nivel_ok) w_next = S_IDLE;
                else if (r_cnt == L_SETTLE)          w_next = S_RUN;
            end
            S_RUN: begin
                if (bus.erro)                            w_next = S_FAULT;
                else if (!bus.nivel_ok)                  w_next = S_COOL;
                else if (r_cnt == L_MAX)                 w_next = S_COOL;
                else if (!w_req_sel && (r_cnt >= L_MIN)) w_next = S_COOL;
            end
            S_COOL: begin
                if (bus.erro)              w_next = S_FAULT;
                else if (r_cnt == L_COOL)  w_next = S_IDLE;
            end
            S_FAULT: begin
                if (bus.clr_fault && !bus.erro) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_vs_d    = (w_next == S_RUN) && !w_sel_next;
        w_bs_d    = (w_next == S_RUN) &&  w_sel_next;
        w_fault_d = (w_next == S_FAULT);
    end

    assign bus.vs_out    = r_vs;
    assign bus.bs_out    = r_bs;
    assign bus.timer_clr = r_timer_clr;
    assign bus.estado    = r_state;
    assign bus.fault     = r_fault;

`ifdef IRRIG_RUNTIME_LOG_EN
    logic [15:0] r_total;

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_total <= '0;
        else if ((r_state == S_RUN) && bus.tick_1hz && (r_total != 16'hFFFF))
            r_total <= r_total + 16'd1;
    end

    assign bus.total_s = r_total;
`else
    assign bus.total_s = '0;
`endif
endmodule
